board_io_debounce: RTL and testbench
====================================

Name: board_io_debounce

Overview:
- Parametrised conditioning block for asynchronous board inputs: switches, buttons and similar, up to NumInputs channels.
- Sits between the board pins and the system general-purpose input bus. Replaces direct pin-to-gp_i wiring.
- Per channel: multi-stage synchroniser, runtime-programmable debounce counter, optional toggle (latch) mode, single-cycle rise/fall event pulses for interrupt generation.

Parameters:
- NumInputs, 8: number of independent input channels.
- SyncStages, 2: flip-flops in each synchroniser chain; legal range 2..4.
- CntWidth, 16: debounce counter width in bits.
- ResetValue, '0: NumInputs-bit reset value for the synchroniser chain, stable state and toggle state.
- ToggleMask, '0: NumInputs-bit mask; bit set = channel runs in toggle mode.

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  reset, asynchronous, active-low.
- in_i  input  NumInputs  raw asynchronous board inputs.
- cfg_cycles_i  input  CntWidth  debounce threshold in clk_sys_i cycles; quasi-static.
- level_o  output  NumInputs  debounced level, or toggle state for channels in toggle mode.
- rise_o  output  NumInputs  one-cycle pulse when level_o bit goes 0->1.
- fall_o  output  NumInputs  one-cycle pulse when level_o bit goes 1->0.
- event_o  output  1  OR-reduction of rise_o|fall_o, registered coincident with them.

Behaviour:
- Reset is asynchronous on rst_sys_ni low:
  - sync chain and stable_q = ResetValue.
  - toggle_q = ResetValue.
  - cnt_q = 0.
  - level_o = ResetValue.
  - rise_o, fall_o and event_o = 0.
- Deassertion is consumed synchronously; no event pulse is generated by leaving reset.
- Synchroniser: in_i passes through SyncStages flops; the output is s. No combinational path from in_i to any output.
- Effective threshold T = max(cfg_cycles_i, 1). cfg_cycles_i = 0 behaves as 1.
- Per-channel debounce state machine, states implicit in (stable_q, cnt_q):
  - IDLE (s == stable_q): cnt_q <= 0.
  - COUNT (s != stable_q, cnt_q < T-1): cnt_q <= cnt_q + 1.
  - COMMIT (s != stable_q, cnt_q >= T-1): stable_q <= s, cnt_q <= 0.
  - A glitch shorter than T cycles at s returns the channel to IDLE and clears cnt_q; stable_q is unchanged.
- Counter never wraps: it clears on COMMIT or IDLE. It is bounded by T-1 ≤ 2^CntWidth-2.
- Threshold changed mid-count: takes effect the same cycle. If cnt_q ≥ new T-1 and s still differs, COMMIT happens on the next edge.
- Latency: a clean in_i edge reaches stable_q after SyncStages + T cycles. level_o reflects stable_q in that same cycle for level channels.
- Toggle mode (ToggleMask bit set):
  - toggle_q inverts on each stable_q 0->1 commit.
  - A stable_q 1->0 commit does nothing.
  - level_o bit = toggle_q.
  - Level-mode bits: level_o = stable_q.
- Edge pulses: a registered comparison of next level against current level.
  - rise_o/fall_o assert high in exactly the first cycle level_o shows the new value, for one cycle.
  - event_o asserts in the same cycle.
- Simultaneous events on multiple channels: each channel pulses independently; event_o is a single pulse.
- A new commit on the cycle immediately after a pulse produces a fresh pulse. Back-to-back pulses are legal when T = 1.
- Channels are fully independent; there is no shared counter.

Test Plan:
- Reset release: ResetValue=8'h0F, in_i=8'h0F held, rst_sys_ni released -> level_o=8'h0F throughout; rise_o, fall_o and event_o stay 0.
- Clean edge: SyncStages=2, cfg_cycles_i=10, in_i[0] 0->1 at cycle 0 -> level_o[0] rises at cycle 12; rise_o[0] and event_o high for cycle 12 only.
- Glitch rejection: cfg_cycles_i=10, in_i[1] high for 9 cycles then low -> level_o[1] stays 0; no pulse. Then high for 10 cycles -> commit, rise_o[1] pulse.
- Toggle mode: ToggleMask=8'h80, cfg_cycles_i=4, three clean press/release pairs on in_i[7] -> level_o[7] sequence 1,0,1. rise_o[7] on presses 1 and 3, fall_o[7] on press 2, nothing on releases.
- Threshold edges:
  - cfg_cycles_i=0: edge commits after SyncStages+1 cycles.
  - cfg_cycles_i=16'hFFFF with CntWidth=16: commits after 2+65535 cycles, no counter wrap.
  - cfg_cycles_i lowered from 100 to 5 while cnt_q=50: commit on the next edge.
- Async reset mid-count and multi-channel:
  - rst_sys_ni pulsed low while cnt_q=7 -> outputs return to ResetValue immediately with no clock.
  - Channels 2 and 5 committing in the same cycle -> rise_o=8'h24, a single event_o pulse.

Source files
------------

// File: rtl/board_io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : board_io_debounce
// Description : Conditioning block for asynchronous board inputs (switches,
//               buttons). Each channel gets a multi-stage synchroniser, a
//               runtime-programmable debounce counter, an optional toggle
//               (latch) mode, and one-cycle rise/fall event pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NumInputs   - number of independent input channels
//   SyncStages  - flops per synchroniser chain (2..4)
//   CntWidth    - debounce counter width in bits
//   ResetValue  - reset value of sync chain, stable and toggle state
//   ToggleMask  - bit set = channel runs in toggle mode
// Ports:
//   clk_sys_i     in   1          system clock
//   rst_sys_ni    in   1          asynchronous active-low reset
//   in_i          in   NumInputs  raw asynchronous board inputs
//   cfg_cycles_i  in   CntWidth   debounce threshold (0 behaves as 1)
//   level_o       out  NumInputs  debounced level / toggle state
//   rise_o        out  NumInputs  one-cycle pulse on level_o 0->1
//   fall_o        out  NumInputs  one-cycle pulse on level_o 1->0
//   event_o       out  1          OR of all rise_o/fall_o bits
// ============================================================================
module board_io_debounce #(
  parameter int unsigned          NumInputs  = 8,
  parameter int unsigned          SyncStages = 2,
  parameter int unsigned          CntWidth   = 16,
  parameter logic [NumInputs-1:0] ResetValue = '0,
  parameter logic [NumInputs-1:0] ToggleMask = '0
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic [NumInputs-1:0] in_i,
  input  logic [CntWidth-1:0]  cfg_cycles_i,
  output logic [NumInputs-1:0] level_o,
  output logic [NumInputs-1:0] rise_o,
  output logic [NumInputs-1:0] fall_o,
  output logic                 event_o
);

  localparam logic [CntWidth-1:0] c_cnt_zero = '0;
  localparam logic [CntWidth-1:0] c_cnt_one  = {{(CntWidth-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Synchroniser chain. Every stage resets to ResetValue so that leaving
  // reset with the pins already at ResetValue produces no activity.
  // --------------------------------------------------------------------------
  logic [NumInputs-1:0] r_sync [SyncStages];
  logic [NumInputs-1:0] w_s;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int k = 0; k < int'(SyncStages); k++) begin
        r_sync[k] <= ResetValue;
      end
    end else begin
      r_sync[0] <= in_i;
      for (int k = 1; k < int'(SyncStages); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SyncStages-1];

  // --------------------------------------------------------------------------
  // Effective threshold minus one. A programmed value of zero is treated as
  // one, so the commit comparison is simply cnt >= T-1 with T-1 never
  // underflowing. The counter therefore tops out at 2^CntWidth-2.
  // --------------------------------------------------------------------------
  logic [CntWidth-1:0] w_thresh_m1;

  assign w_thresh_m1 = (cfg_cycles_i == c_cnt_zero) ? c_cnt_zero
                                                    : (cfg_cycles_i - c_cnt_one);

  // --------------------------------------------------------------------------
  // Per-channel debounce. The state is implicit in (stable, cnt):
  //   s == stable             -> idle, counter cleared
  //   s != stable, cnt < T-1  -> keep counting
  //   s != stable, cnt >= T-1 -> commit s into stable, counter cleared
  // Any return of s to the stable value before commit clears the counter,
  // which is what rejects glitches shorter than T cycles.
  // --------------------------------------------------------------------------
  logic [NumInputs-1:0] w_commit;
  logic [NumInputs-1:0] w_level_nxt;

  for (genvar i = 0; i < int'(NumInputs); i++) begin : g_ch
    logic                r_stable;
    logic [CntWidth-1:0] r_cnt;
    logic                w_differs;

    assign w_differs   = (w_s[i] != r_stable);
    // The threshold is compared live, so lowering it below the current
    // count commits on the very next edge.
    assign w_commit[i] = w_differs && (r_cnt >= w_thresh_m1);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
        r_stable <= ResetValue[i];
        r_cnt    <= c_cnt_zero;
      end else if (!w_differs) begin
        r_cnt    <= c_cnt_zero;
      end else if (w_commit[i]) begin
        r_stable <= w_s[i];
        r_cnt    <= c_cnt_zero;
      end else begin
        r_cnt    <= r_cnt + c_cnt_one;
      end
    end

    if (ToggleMask[i]) begin : g_toggle
      // Latch behaviour: only a committed press (stable 0->1) flips the
      // output; a committed release leaves it alone.
      logic r_toggle;
      logic w_toggle_nxt;

      assign w_toggle_nxt = r_toggle ^ (w_commit[i] & w_s[i]);

      always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
          r_toggle <= ResetValue[i];
        end else begin
          r_toggle <= w_toggle_nxt;
        end
      end

      assign w_level_nxt[i] = w_toggle_nxt;
    end else begin : g_level
      assign w_level_nxt[i] = w_commit[i] ? w_s[i] : r_stable;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage. The level register is loaded with the same next value that
  // feeds stable/toggle, so level_o changes on the commit edge itself. The
  // edge pulses compare that next value against the currently shown level,
  // placing each pulse in exactly the first cycle of the new level.
  // --------------------------------------------------------------------------
  logic [NumInputs-1:0] r_level;
  logic [NumInputs-1:0] r_rise;
  logic [NumInputs-1:0] r_fall;
  logic                 r_event;
  logic [NumInputs-1:0] w_rise_nxt;
  logic [NumInputs-1:0] w_fall_nxt;

  assign w_rise_nxt = w_level_nxt & ~r_level;
  assign w_fall_nxt = ~w_level_nxt & r_level;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_level <= ResetValue;
      r_rise  <= '0;
      r_fall  <= '0;
      r_event <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_event <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign event_o = r_event;

endmodule
`default_nettype wire

// File: tb/tb_board_io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_io_debounce
// Description : Self-checking bench for board_io_debounce. A directed vector
//               table and hand sequences are combined with a cycle-level
//               reference model built on run lengths and toggle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_debounce;

  localparam int          SS  = 2;
  localparam logic [7:0]  RV  = 8'h00;
  localparam logic [7:0]  TM  = 8'h80;
  localparam logic [7:0]  RV2 = 8'h0F;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  in_i  = 8'h00;
  logic [15:0] cfg   = 16'd10;
  logic [7:0]  level, rise, fall;
  logic        ev;

  logic [7:0]  in2  = 8'h0F;
  logic [15:0] cfg2 = 16'd10;
  logic [7:0]  level2, rise2, fall2;
  logic        ev2;

  always #5 clk = ~clk;

  board_io_debounce #(
    .NumInputs(8), .SyncStages(SS), .CntWidth(16),
    .ResetValue(RV), .ToggleMask(TM)
  ) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .in_i(in_i), .cfg_cycles_i(cfg),
    .level_o(level), .rise_o(rise), .fall_o(fall), .event_o(ev)
  );

  board_io_debounce #(
    .NumInputs(8), .SyncStages(SS), .CntWidth(16),
    .ResetValue(RV2), .ToggleMask(8'h00)
  ) dut_rv (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .in_i(in2), .cfg_cycles_i(cfg2),
    .level_o(level2), .rise_o(rise2), .fall_o(fall2), .event_o(ev2)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_pipe [SS];
  logic [7:0] m_stable, m_toggle, m_level, m_rise, m_fall;
  logic       m_ev;
  int         m_run [8];

  function automatic void model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = RV;
    m_stable = RV;
    m_toggle = RV;
    m_level  = RV;
    m_rise   = 8'h00;
    m_fall   = 8'h00;
    m_ev     = 1'b0;
    for (int c = 0; c < 8; c++) m_run[c] = 0;
  endfunction

  // A channel commits once the synchronised input has disagreed with the
  // stable value for T consecutive cycles (T = max(cfg,1)).
  function automatic void model_step();
    logic [7:0] s, nl, tm;
    int t;
    tm = TM;
    t  = (cfg == 16'd0) ? 1 : int'(cfg);
    s  = m_pipe[SS-1];
    for (int c = 0; c < 8; c++) begin
      if (s[c] != m_stable[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] >= t) begin
          m_stable[c] = s[c];
          m_run[c]    = 0;
          if (tm[c] && s[c]) m_toggle[c] = ~m_toggle[c];
        end
      end else begin
        m_run[c] = 0;
      end
    end
    nl      = (m_toggle & tm) | (m_stable & ~tm);
    m_rise  = nl & ~m_level;
    m_fall  = ~nl & m_level;
    m_ev    = |(m_rise | m_fall);
    m_level = nl;
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = in_i;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk8("m_level", level, m_level);
    chk8("m_rise",  rise,  m_rise);
    chk8("m_fall",  fall,  m_fall);
    chk1("m_event", ev,    m_ev);
    chk8("rv_level", level2, RV2);
    chk1("rv_event", ev2 | (|rise2) | (|fall2), 1'b0);
  endtask

  task automatic step_only();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
  endtask

  task automatic tick();
    step_only();
    check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  in;
    logic [15:0] cfg;
    int          ticks;
    logic [7:0]  lvl;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        ev;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{8'h00, 16'd10, 5,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'h10, 16'd10, 11, 8'h00, 8'h00, 8'h00, 1'b0};  // clean edge
    tbl[2]  = '{8'h10, 16'd10, 1,  8'h10, 8'h10, 8'h00, 1'b1};  // cycle 12
    tbl[3]  = '{8'h10, 16'd10, 1,  8'h10, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{8'h50, 16'd10, 9,  8'h10, 8'h00, 8'h00, 1'b0};  // 9-cycle glitch
    tbl[5]  = '{8'h10, 16'd10, 12, 8'h10, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{8'h50, 16'd10, 12, 8'h50, 8'h40, 8'h00, 1'b1};  // 10+ cycles
    tbl[7]  = '{8'h50, 16'd10, 1,  8'h50, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h00, 16'd10, 12, 8'h00, 8'h00, 8'h50, 1'b1};
    tbl[9]  = '{8'h24, 16'd10, 12, 8'h24, 8'h24, 8'h00, 1'b1};  // ch2+ch5
    tbl[10] = '{8'h24, 16'd10, 1,  8'h24, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{8'h00, 16'd10, 12, 8'h00, 8'h00, 8'h24, 1'b1};
    tbl[12] = '{8'h01, 16'd0,  2,  8'h00, 8'h00, 8'h00, 1'b0};  // cfg 0
    tbl[13] = '{8'h01, 16'd0,  1,  8'h01, 8'h01, 8'h00, 1'b1};
    tbl[14] = '{8'h00, 16'd0,  3,  8'h00, 8'h00, 8'h01, 1'b1};
    tbl[15] = '{8'h80, 16'd4,  6,  8'h80, 8'h80, 8'h00, 1'b1};  // press 1
    tbl[16] = '{8'h00, 16'd4,  6,  8'h80, 8'h00, 8'h00, 1'b0};
    tbl[17] = '{8'h80, 16'd4,  6,  8'h00, 8'h00, 8'h80, 1'b1};  // press 2
    tbl[18] = '{8'h00, 16'd4,  6,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[19] = '{8'h80, 16'd4,  6,  8'h80, 8'h80, 8'h00, 1'b1};  // press 3
    tbl[20] = '{8'h00, 16'd4,  6,  8'h80, 8'h00, 8'h00, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk8("reset_level", level, RV);
    chk1("reset_event", ev | (|rise) | (|fall), 1'b0);
    chk8("reset_level_rv", level2, RV2);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      in_i = tbl[i].in;
      cfg  = tbl[i].cfg;
      for (int n = 0; n < tbl[i].ticks; n++) tick();
      chk8($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk8($sformatf("vec%0d_rise", i),  rise,  tbl[i].rise);
      chk8($sformatf("vec%0d_fall", i),  fall,  tbl[i].fall);
      chk1($sformatf("vec%0d_event", i), ev,    tbl[i].ev);
    end

    // Threshold lowered from 100 to 5 while the count sits at 50.
    in_i = 8'h01;
    cfg  = 16'd100;
    for (int n = 0; n < 52; n++) tick();
    chk8("thr_lower_before", level, 8'h80);
    cfg = 16'd5;
    tick();
    chk8("thr_lower_level", level, 8'h81);
    chk8("thr_lower_rise",  rise,  8'h01);

    // Asynchronous reset mid-count (channel 4 count at 7), no clock edge.
    in_i = 8'h11;
    cfg  = 16'd10;
    for (int n = 0; n < 9; n++) tick();
    chk8("pre_reset_level", level, 8'h81);
    rst_n = 1'b0;
    #1;
    chk8("async_reset_level", level, RV);
    chk1("async_reset_pulses", ev | (|rise) | (|fall), 1'b0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) tick();
    chk8("post_reset_level", level, 8'h11);
    chk8("post_reset_rise",  rise,  8'h11);
    in_i = 8'h00;
    for (int n = 0; n < 14; n++) tick();

    // Maximum threshold: 2 + 65535 cycles, counter must not wrap.
    in_i = 8'h02;
    cfg  = 16'hFFFF;
    for (int n = 0; n < 65536; n++) step_only();
    check_model();
    chk8("max_thr_before", level, 8'h00);
    tick();
    chk8("max_thr_level", level, 8'h02);
    chk8("max_thr_rise",  rise,  8'h02);
    in_i = 8'h00;
    cfg  = 16'd1;
    for (int n = 0; n < 4; n++) tick();

    // Back-to-back commits with T = 1.
    for (int n = 0; n < 8; n++) begin
      in_i = (n % 2 == 0) ? 8'h08 : 8'h00;
      tick();
    end
    for (int n = 0; n < 4; n++) tick();

    // Randomised run against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 5) == 0) in_i[c] = ~in_i[c];
      end
      if ($urandom_range(0, 63) == 0) cfg = 16'($urandom_range(0, 5));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
